// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Accepts a program image as a byte stream (valid/ready), assembles
// little-endian 32-bit words and issues one-cycle word writes into IMEM.
// The first four bytes of an image are the word count N. The core is held
// stalled until the whole image has been written.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  one-cycle pulse, starts a load from IDLE/DONE/ERR
//   byte_valid, byte_data  host byte stream
//   byte_ready             loader accepts a byte this cycle (LEN/DATA only)
//   imem_we                one-cycle IMEM write strobe
//   imem_addr              byte address of the write (bits [1:0] always 0)
//   imem_wdata             instruction word being written
//   busy                   load in progress (LEN/DATA/WRITE)
//   load_done              image fully written
//   load_err               declared length exceeds IMEM capacity
//   cpu_hold               core stall request (low only in DONE)
module imem_loader #(
  parameter int unsigned INST_WIDTH_LENGTH = 32,
  parameter int unsigned PC_WIDTH_LENGTH   = 32,
  parameter int unsigned MAX_MEM_DEPTH_BIT = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         byte_ready,
  output logic                         imem_we,
  output logic [PC_WIDTH_LENGTH-1:0]   imem_addr,
  output logic [INST_WIDTH_LENGTH-1:0] imem_wdata,
  output logic                         busy,
  output logic                         load_done,
  output logic                         load_err,
  output logic                         cpu_hold
);

  // Word index width: capacity is 2^IDX_W words, indices 0 .. 2^IDX_W-1.
  localparam int unsigned IDX_W = MAX_MEM_DEPTH_BIT - 1;
  localparam logic [INST_WIDTH_LENGTH-1:0] CAP_WORDS =
    INST_WIDTH_LENGTH'(1) << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                       state_q;
  logic [1:0]                   byte_cnt_q;
  logic [IDX_W-1:0]             word_idx_q;
  logic [INST_WIDTH_LENGTH-1:0] len_q;
  logic [INST_WIDTH_LENGTH-1:0] asm_q;
  logic                         byte_ready_q;
  logic                         imem_we_q;
  logic [PC_WIDTH_LENGTH-1:0]   imem_addr_q;
  logic [INST_WIDTH_LENGTH-1:0] imem_wdata_q;
  logic                         busy_q;
  logic                         load_done_q;
  logic                         load_err_q;
  logic                         cpu_hold_q;

  logic                         accept;
  logic [INST_WIDTH_LENGTH-1:0] word_d;
  logic                         last_word;

  assign accept = byte_valid && byte_ready_q;

  // Shift bytes in from the top so the first accepted byte ends up in [7:0].
  assign word_d = {byte_data, asm_q[INST_WIDTH_LENGTH-1:8]};

  assign last_word = (INST_WIDTH_LENGTH'(word_idx_q) == (len_q - INST_WIDTH_LENGTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      imem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LEN;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            len_q        <= '0;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
          end
        end

        S_LEN: begin
          if (accept) begin
            asm_q      <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              len_q <= word_d;
              if (word_d == '0) begin
                state_q      <= S_DONE;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
                load_done_q  <= 1'b1;
                cpu_hold_q   <= 1'b0;
              end else if (word_d > CAP_WORDS) begin
                state_q      <= S_ERR;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
                load_err_q   <= 1'b1;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            asm_q      <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // Strobe is registered so the write cycle is the WRITE state itself.
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              imem_we_q    <= 1'b1;
              imem_wdata_q <= word_d;
              imem_addr_q  <= PC_WIDTH_LENGTH'({word_idx_q, 2'b00});
            end
          end
        end

        S_WRITE: begin
          if (last_word) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
          end else begin
            state_q      <= S_DATA;
            word_idx_q   <= word_idx_q + IDX_W'(1);
            byte_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign cpu_hold   = cpu_hold_q;

endmodule
